// File: rtl/mem_responder_if.sv
// CPU data-port bundle between a requester (master) and the memory responder (slave).
interface mem_responder_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        ack;
  logic [31:0] rdata;
  logic        err;
  logic        busy;

  modport master (output req, we, addr, wdata, input ack, rdata, err, busy);
  modport slave  (input req, we, addr, wdata, output ack, rdata, err, busy);
endinterface

// File: rtl/mem_responder.sv
// Word-addressed memory slave with a fixed response latency of WAIT_CYCLES+1
// cycles after acceptance, one-cycle ack strobe and alignment/range fault reporting.
module mem_responder #(
  parameter int WAIT_CYCLES = 2,
  parameter int DEPTH       = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  mem_responder_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        ack_q, ack_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic        mem_we;
  logic        fault;
  logic [AW-1:0] idx;
  logic [31:0] mem_q [DEPTH];

  // Anything above the storage range, or a misaligned byte offset, is a fault.
  assign idx   = addr_q[AW+1:2];
  assign fault = (addr_q[1:0] != 2'b00) || (|addr_q[31:AW+2]);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    ack_d   = 1'b0;
    rdata_d = '0;
    err_d   = 1'b0;
    mem_we  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.req) begin
          we_d    = bus.we;
          addr_d  = bus.addr;
          wdata_d = bus.wdata;
          cnt_d   = 4'(WAIT_CYCLES);
          state_d = (WAIT_CYCLES == 0) ? RESP : WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = RESP;
      end
      RESP: begin
        // The edge leaving RESP raises ack and performs the access itself.
        ack_d   = 1'b1;
        state_d = IDLE;
        if (fault)     err_d   = 1'b1;
        else if (we_q) mem_we  = 1'b1;
        else           rdata_d = mem_q[idx];
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      ack_q   <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      ack_q   <= ack_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (mem_we) begin
      mem_q[idx] <= wdata_q;
    end
  end

  assign bus.ack   = ack_q;
  assign bus.rdata = rdata_q;
  assign bus.err   = err_q;
  // The ack cycle already sits in IDLE, so it is folded into busy explicitly.
  assign bus.busy  = (state_q != IDLE) || ack_q;
endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter WAIT_CYCLES, default 2: idle cycles inserted between request acceptance and response; legal range 0..15.
REQ-002 Parameter DEPTH, default 64: number of 32-bit words in storage; legal range 2..256, power of two.
REQ-003 CLK  input  1  single clock; all state changes on the rising edge.
REQ-004 Reset  input  1  asynchronous, active-low reset.
REQ-005 req  input  1  request valid from the CPU data port.
REQ-006 we  input  1  1 = store, 0 = load; sampled with req.
REQ-007 addr  input  32  byte address; word-aligned accesses only.
REQ-008 wdata  input  32  store data; sampled with req.
REQ-009 ack  output  1  one-cycle response strobe.
REQ-010 rdata  output  32  load data; valid while ack=1.
REQ-011 err  output  1  access fault flag; valid while ack=1.
REQ-012 busy  output  1  high whenever a request is in flight (state not IDLE).

Function
REQ-013 The block SHALL implement an FSM with states IDLE, WAIT and RESP.
REQ-014 In IDLE with req=1 at a rising edge (E0), the block SHALL latch we, addr and wdata, load the wait counter with WAIT_CYCLES, and go to WAIT (WAIT_CYCLES>0) or RESP (WAIT_CYCLES=0).
REQ-015 In WAIT the counter SHALL decrement once per edge; the edge on which it reaches 0 moves to RESP.
REQ-016 ack SHALL be high exactly one cycle, starting at edge E0+WAIT_CYCLES+1; RESP lasts one cycle, then returns to IDLE unconditionally.
REQ-017 req, we, addr and wdata SHALL be ignored in WAIT and RESP; input changes after E0 do not affect the in-flight access.
REQ-018 The requester holds req until it sees ack and drops it in the ack cycle; if req is still high in RESP, it is treated as a new request only once the FSM is back in IDLE (minimum spacing WAIT_CYCLES+2 cycles between acceptances).
REQ-019 Word index SHALL be addr[log2(DEPTH)+1:2]; fault when addr[1:0]!=0 or addr>>2 >= DEPTH.
REQ-020 Valid store: memory word SHALL be written with the latched wdata on the edge that raises ack; rdata=0, err=0 during ack.
REQ-021 Valid load: rdata SHALL equal the stored word, registered on the edge that raises ack; err=0.
REQ-022 Faulted access: no memory write; rdata=0 and err=1 during ack.
REQ-023 A load that follows a store to the same word SHALL return the stored value (no stale read).
REQ-024 rdata and err SHALL return to 0 on the edge that lowers ack.
REQ-025 busy SHALL be high from edge E0 through the ack cycle inclusive, and low in IDLE.

Reset
REQ-026 Reset=0 SHALL asynchronously force state IDLE, counter 0, ack=0, err=0, rdata=0, busy=0, and clear all DEPTH words to 0.
REQ-027 Reset asserted mid-access SHALL discard the pending access (no write, no ack); after release the first edge with req=1 starts a fresh access.
REQ-028 Outputs SHALL hold their reset values while Reset=0 regardless of CLK or req.

Verification
REQ-029 WAIT_CYCLES=2: store addr=0x0000_0010, wdata=0xDEAD_BEEF accepted at E0 -> ack=1, err=0 exactly after E3 for one cycle, busy high E0..ack cycle; then load 0x10 -> rdata=0xDEAD_BEEF with ack.
REQ-030 WAIT_CYCLES=0: load from reset-cleared addr 0x04 -> ack after E1, rdata=0x0000_0000, err=0; req held high through RESP -> next acceptance at E2, second ack after E3.
REQ-031 Faults: load addr=0x0000_0006 -> ack with err=1, rdata=0; store addr=0x0000_0100 (DEPTH=64) with wdata=0x1234_5678 -> err=1, and subsequent load of 0x00 returns 0 (no aliasing write).
REQ-032 Input change after accept: store addr=0x08 wdata=0x1111_1111, then change wdata to 0x2222_2222 during WAIT -> load 0x08 returns 0x1111_1111.
REQ-033 Reset mid-access: store 0x0C wdata=0xA5A5_A5A5, pull Reset low one cycle after E0 -> ack never rises, busy=0 immediately; after release load 0x0C -> rdata=0.
REQ-034 Back-to-back: stores to 0x00..0x3C incrementing data, then loads in reverse order -> every rdata matches, ack count equals request count, no ack without prior accepted req.
